// File: rtl/bus_uart_tx_pkg.sv
// Shared register map, bit positions and serialiser state type for the bus UART transmitter.
package bus_uart_tx_pkg;

    localparam logic [3:0] RegTxDataOffset  = 4'h0;
    localparam logic [3:0] RegStatusOffset  = 4'h4;
    localparam logic [3:0] RegCtrlOffset    = 4'h8;
    localparam logic [3:0] RegBaudDivOffset = 4'hC;

    localparam int unsigned StatusFull     = 0;
    localparam int unsigned StatusEmpty    = 1;
    localparam int unsigned StatusBusy     = 2;
    localparam int unsigned StatusLevelLsb = 8;

    localparam int unsigned CtrlTxEn  = 0;
    localparam int unsigned CtrlIrqEn = 1;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Show-ahead synchronous FIFO; head entry is always visible on rdata_o.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [PtrW-1:0] PtrMask = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LvlW'(Depth));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q + PtrW'(1)) & PtrMask;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q + PtrW'(1)) & PtrMask;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: device-bus register block, TX FIFO and baud-rate serialiser.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter int unsigned FifoDepth      = 8,
    parameter int unsigned DefaultBaudDiv = 16,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [AddressWidth-1:0] addr_i,
    input  logic [DataWidth-1:0]    wdata_i,
    output logic                    rvalid_o,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    err_o,
    output logic                    tx_o,
    output logic                    irq_o
);

    localparam int unsigned LvlW = $clog2(FifoDepth) + 1;

    logic [LvlW-1:0]      level;
    logic                 full, empty, push, pop;
    logic [7:0]           head;
    logic                 addr_ok, wr, rd, push_req, push_err;
    logic                 sel_txdata, sel_ctrl, sel_baud;
    logic [3:0]           reg_offset;
    logic [DataWidth-1:0] rdata_d;
    logic [15:0]          div_eff, bit_reload;
    logic                 bit_end;

    logic                 rvalid_q, err_q;
    logic [DataWidth-1:0] rdata_q;
    logic [1:0]           ctrl_q;
    logic [15:0]          baud_div_q;

    tx_state_e            state_q;
    logic [7:0]           shift_q;
    logic [2:0]           bit_cnt_q;
    logic [15:0]          baud_cnt_q;
    logic                 tx_q, irq_q;

    logic                 unused_bits;
    assign unused_bits = ^{addr_i[AddressWidth-1:10], addr_i[1:0], be_i[3:2],
                           wdata_i[DataWidth-1:16]};

    sync_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (wdata_i[7:0]),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign addr_ok    = (addr_i[9:4] == '0);
    assign reg_offset = {addr_i[3:2], 2'b00};
    assign sel_txdata = (reg_offset == RegTxDataOffset);
    assign sel_ctrl   = (reg_offset == RegCtrlOffset);
    assign sel_baud   = (reg_offset == RegBaudDivOffset);
    assign wr         = req_i & we_i & addr_ok;
    assign rd         = req_i & ~we_i & addr_ok;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot.
    assign push_req = wr & sel_txdata & be_i[0];
    assign push     = push_req & ~full;
    assign push_err = push_req & full;
    assign pop      = (state_q == TxIdle) & ctrl_q[CtrlTxEn] & ~empty;

    assign div_eff    = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
    assign bit_reload = div_eff - 16'd1;
    assign bit_end    = (baud_cnt_q == 16'd0);

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (reg_offset)
                RegStatusOffset: begin
                    rdata_d[StatusFull]            = full;
                    rdata_d[StatusEmpty]           = empty;
                    rdata_d[StatusBusy]            = (state_q != TxIdle);
                    rdata_d[StatusLevelLsb +: 8]   = 8'(level);
                end
                RegCtrlOffset:    rdata_d[1:0]  = ctrl_q;
                RegBaudDivOffset: rdata_d[15:0] = baud_div_q;
                default:          rdata_d       = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            baud_div_q <= 16'(DefaultBaudDiv);
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i & (~addr_ok | push_err);
            rdata_q  <= rdata_d;
            if (wr && sel_ctrl && be_i[0]) begin
                ctrl_q <= wdata_i[1:0];
            end
            if (wr && sel_baud) begin
                if (be_i[0]) baud_div_q[7:0]  <= wdata_i[7:0];
                if (be_i[1]) baud_div_q[15:8] <= wdata_i[15:8];
            end
        end
    end

    // Serialiser: each bit period reloads from BAUD_DIV, so divider writes land on bit boundaries.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= TxIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            irq_q <= ctrl_q[CtrlIrqEn] & empty & (state_q == TxIdle);
            case (state_q)
                TxIdle: begin
                    if (pop) begin
                        shift_q    <= head;
                        baud_cnt_q <= bit_reload;
                        tx_q       <= 1'b0;
                        state_q    <= TxStart;
                    end
                end
                TxStart: begin
                    if (bit_end) begin
                        tx_q       <= shift_q[0];
                        shift_q    <= shift_q >> 1;
                        bit_cnt_q  <= '0;
                        baud_cnt_q <= bit_reload;
                        state_q    <= TxData;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TxData: begin
                    if (bit_end) begin
                        baud_cnt_q <= bit_reload;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= TxStop;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                TxStop: begin
                    if (bit_end) begin
                        state_q <= TxIdle;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 16'd1;
                    end
                end
                default: state_q <= TxIdle;
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;
    assign tx_o     = tx_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed/randomised bench for bus_uart_tx; serial waveforms are predicted from byte queues.
module tb_bus_uart_tx;

    localparam logic [31:0] AddrTxData = 32'h0;
    localparam logic [31:0] AddrStatus = 32'h4;
    localparam logic [31:0] AddrCtrl   = 32'h8;
    localparam logic [31:0] AddrBaud   = 32'hC;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o, err_o, tx_o, irq_o;
    logic [31:0] rdata_o;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(
        .FifoDepth      (8),
        .DefaultBaudDiv (16),
        .DataWidth      (32),
        .AddressWidth   (32)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .tx_o     (tx_o),
        .irq_o    (irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wave(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        @(negedge clk);
        chk("rvalid_idle", 32'(rvalid_o), 32'd0);
        req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; be_i = '0;
        chk("rvalid", 32'(rvalid_o), 32'd1);
        rd = rdata_o;
        er = err_o;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic exp_err, input string tag);
        logic [31:0] r;
        logic e;
        bus(1'b1, a, be, d, r, e);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
        chk({tag, "_rdata"}, r, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_err,
                      input string tag);
        logic [31:0] r;
        logic e;
        bus(1'b0, a, 4'hF, 32'd0, r, e);
        chk({tag, "_rdata"}, r, exp);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    // Line model: start, 8 data bits LSB first, stop (div clocks each), then one high IDLE cycle
    // in which the next pop happens. irq is expected only on the sample after the final IDLE cycle.
    task automatic expect_wave(input int div, input logic [7:0] bytes[$], input logic irq_on,
                               input string tag);
        int eff;
        logic exp_tx[$];
        logic [255:0] ov, ev, oi, ei;
        logic found;
        eff = (div == 0) ? 1 : div;
        foreach (bytes[k]) begin
            repeat (eff) exp_tx.push_back(1'b0);
            for (int b = 0; b < 8; b++) repeat (eff) exp_tx.push_back(bytes[k][b]);
            repeat (eff + 1) exp_tx.push_back(1'b1);
        end
        exp_tx.push_back(1'b1);
        ov = '0; ev = '0; oi = '0; ei = '0;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                if (i > 0) @(negedge clk);
                ov[i] = tx_o;
                oi[i] = irq_o;
                ev[i] = exp_tx[i];
            end
            ei[exp_tx.size() - 1] = irq_on;
            chk_wave({tag, "_tx"}, ov, ev);
            chk_wave({tag, "_irq"}, oi, ei);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] model_q[$];
        logic [7:0] b, b0, b1;
        logic       exp_err, found, all_high;
        int         d;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_ni = 1'b1;

        rd(AddrStatus, 32'h2, 1'b0, "status_rst");
        chk("rst_tx_after", 32'(tx_o), 32'd1);
        chk("rst_irq_after", 32'(irq_o), 32'd0);
        rd(AddrBaud, 32'h10, 1'b0, "baud_rst");
        rd(AddrCtrl, 32'h0, 1'b0, "ctrl_rst");
        rd(AddrTxData, 32'h0, 1'b0, "txdata_rd");
        wr(AddrStatus, 4'hF, 32'hFFFF_FFFF, 1'b0, "status_wr");
        rd(AddrStatus, 32'h2, 1'b0, "status_after_wr");

        // CTRL masking, byte enables, and irq on empty+idle
        wr(AddrCtrl, 4'h1, 32'hFFFF_FFFF, 1'b0, "ctrl_wr");
        rd(AddrCtrl, 32'h3, 1'b0, "ctrl_mask");
        chk("irq_on_idle", 32'(irq_o), 32'd1);
        wr(AddrCtrl, 4'hE, 32'h0, 1'b0, "ctrl_be_off");
        rd(AddrCtrl, 32'h3, 1'b0, "ctrl_be_hold");
        wr(AddrCtrl, 4'h1, 32'h0, 1'b0, "ctrl_clr");
        @(negedge clk);
        chk("irq_off", 32'(irq_o), 32'd0);

        wr(AddrBaud, 4'h1, 32'hABCD_1234, 1'b0, "baud_b0");
        rd(AddrBaud, 32'h34, 1'b0, "baud_b0_rd");
        wr(AddrBaud, 4'h2, 32'h0000_5600, 1'b0, "baud_b1");
        rd(AddrBaud, 32'h5634, 1'b0, "baud_b1_rd");

        // 0xA5 frame at div 4, with a STATUS read mid-frame
        wr(AddrBaud, 4'hF, 32'hFFFF_0004, 1'b0, "baud4");
        rd(AddrBaud, 32'h4, 1'b0, "baud4_rd");
        wr(AddrCtrl, 4'h1, 32'h1, 1'b0, "ctrl_txen");
        wr(AddrTxData, 4'h1, 32'h0000_00A5, 1'b0, "push_a5");
        q.delete();
        q.push_back(8'hA5);
        fork
            expect_wave(4, q, 1'b0, "a5");
            begin
                repeat (12) @(negedge clk);
                rd(AddrStatus, 32'h6, 1'b0, "status_busy");
            end
        join
        rd(AddrStatus, 32'h2, 1'b0, "status_after_a5");

        // Random byte at a random divider
        d = int'($urandom_range(6, 2));
        wr(AddrBaud, 4'h3, 32'(d), 1'b0, "baud_rnd");
        b = 8'($urandom);
        wr(AddrTxData, 4'h1, {24'($urandom), b}, 1'b0, "push_rnd");
        q.delete();
        q.push_back(b);
        expect_wave(d, q, 1'b0, "rnd");

        // Byte-enable gating of TXDATA, then fill to overflow with tx disabled
        wr(AddrCtrl, 4'h1, 32'h0, 1'b0, "ctrl_off");
        wr(AddrTxData, 4'hE, 32'h0000_0055, 1'b0, "push_nobe");
        rd(AddrStatus, 32'h2, 1'b0, "status_nobe");
        model_q.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_err = (model_q.size() == 8);
            wr(AddrTxData, 4'h1, {24'($urandom), b}, exp_err, "fill");
            if (!exp_err) model_q.push_back(b);
            if (i == 7) rd(AddrStatus, 32'h801, 1'b0, "status_full");
        end
        rd(AddrStatus, 32'h801, 1'b0, "status_full_hold");

        // Drain all 8 at BAUD_DIV=0 (behaves as 1)
        wr(AddrBaud, 4'h3, 32'h0, 1'b0, "baud0");
        wr(AddrCtrl, 4'h1, 32'h1, 1'b0, "ctrl_drain");
        expect_wave(0, model_q, 1'b0, "drain");
        model_q.delete();
        rd(AddrStatus, 32'h2, 1'b0, "status_drained");

        // Back-to-back 0x01, 0x02 at div 1 with irq enabled
        wr(AddrCtrl, 4'h1, 32'h0, 1'b0, "ctrl_off2");
        wr(AddrBaud, 4'h3, 32'h1, 1'b0, "baud1");
        wr(AddrTxData, 4'h1, 32'h01, 1'b0, "push_01");
        wr(AddrTxData, 4'h1, 32'h02, 1'b0, "push_02");
        chk("irq_pending_data", 32'(irq_o), 32'd0);
        wr(AddrCtrl, 4'h1, 32'h3, 1'b0, "ctrl_irq");
        q.delete();
        q.push_back(8'h01);
        q.push_back(8'h02);
        expect_wave(1, q, 1'b1, "irq");
        wr(AddrCtrl, 4'h1, 32'h0, 1'b0, "ctrl_off3");
        @(negedge clk);
        chk("irq_cleared", 32'(irq_o), 32'd0);

        // tx_en cleared during bit 3: frame completes, second byte stays queued
        wr(AddrBaud, 4'h3, 32'h4, 1'b0, "baud4b");
        b0 = 8'($urandom);
        b1 = 8'($urandom) & 8'hFD;
        wr(AddrTxData, 4'h1, 32'(b0), 1'b0, "push_b0");
        wr(AddrTxData, 4'h1, 32'(b1), 1'b0, "push_b1");
        wr(AddrCtrl, 4'h1, 32'h1, 1'b0, "ctrl_txen2");
        q.delete();
        q.push_back(b0);
        fork
            expect_wave(4, q, 1'b0, "txen");
            begin
                found = 1'b0;
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (tx_o === 1'b0) begin
                        found = 1'b1;
                        break;
                    end
                end
                chk("txen_seen", 32'(found), 32'd1);
                repeat (17) @(negedge clk);
                wr(AddrCtrl, 4'h1, 32'h0, 1'b0, "txen_clr");
            end
        join
        all_high = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_o !== 1'b1) all_high = 1'b0;
        end
        chk("txen_hold_high", 32'(all_high), 32'd1);
        rd(AddrStatus, 32'h100, 1'b0, "txen_level");

        // Decode errors and upper-address aliasing
        rd(32'h10, 32'h0, 1'b1, "bad_rd");
        wr(32'h3F0, 4'h1, 32'h77, 1'b1, "bad_wr");
        rd(32'h0000_1404, 32'h100, 1'b0, "alias_status");

        // Reset during DATA (bit 1 of b1, forced to 0)
        wr(AddrCtrl, 4'h1, 32'h1, 1'b0, "ctrl_txen3");
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tx_o === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_frame_seen", 32'(found), 32'd1);
        repeat (8) @(negedge clk);
        chk("pre_rst_tx", 32'(tx_o), 32'd0);
        rst_ni = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx", 32'(tx_o), 32'd1);
        chk("mid_rst_irq", 32'(irq_o), 32'd0);
        rst_ni = 1'b1;
        rd(AddrStatus, 32'h2, 1'b0, "status_post_rst");
        rd(AddrBaud, 32'h10, 1'b0, "baud_post_rst");
        rd(AddrCtrl, 32'h0, 1'b0, "ctrl_post_rst");
        all_high = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_o !== 1'b1) all_high = 1'b0;
        end
        chk("post_rst_idle", 32'(all_high), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
